// File: rtl/bcd7seg_pkg.sv
// Shared constants and helpers for the BCD 7-segment scan driver.
// Segment patterns are {a,b,c,d,e,f,g} in bits 6..0, active-high.
package bcd7seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Non-decimal codes (10..15) decode to all segments off.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd7seg_decode.sv
// Combinational BCD digit to a..g segment decoder.
module bcd7seg_decode
    import bcd7seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure table lookup; shared with anything else that needs the pattern.
    assign seg = seg_decode(bcd);

endmodule

// File: rtl/bcd7segment_scan.sv
// Time-multiplexed 7-segment driver: shadow-registered BCD word, round-robin
// digit scan with a programmable slot length and dark cycles at the start of
// each slot to suppress ghosting between digits.
// Optional feature macro: BCD7SEG_LZB_EN (leading-zero blanking, mask taken
// at Load time).
module bcd7segment_scan
    import bcd7seg_pkg::*;
#(
    parameter int DIGITS    = 4,     // 1..16
    parameter int SCAN_DIV  = 1000,  // clocks per digit slot, >= 2
    parameter int BLANK_CYC = 1      // dark clocks per slot, 0..SCAN_DIV-1
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                En,
    input  logic                Load,
    input  logic [4*DIGITS-1:0] BCD,
    input  logic [DIGITS-1:0]   DP,
    output logic [7:0]          Segment,
    output logic [DIGITS-1:0]   DigitSel,
    output logic                ScanTick
);

    localparam int              CW       = cnt_width(SCAN_DIV);
    localparam int              IW       = cnt_width(DIGITS);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   CNT_LIT  = CW'(BLANK_CYC);
    localparam logic [IW-1:0]   IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]            cnt;
    logic [IW-1:0]            idx;
    logic [DIGITS-1:0][3:0]   bcd_sh;
    logic [DIGITS-1:0]        dp_sh;
    logic [3:0]               cur_bcd;
    logic [6:0]               cur_seg;
    logic [6:0]               lit_seg;
    logic                     lit;

    // Prescaler and digit index; both freeze while scanning is disabled.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
            idx <= '0;
        end else if (En) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Shadow capture; reset value 4'hF decodes dark so nothing shows before Load.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bcd_sh <= '1;
            dp_sh  <= '0;
        end else if (Load) begin
            bcd_sh <= BCD;
            dp_sh  <= DP;
        end
    end

    assign cur_bcd = bcd_sh[idx];

    bcd7seg_decode u_dec (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

`ifdef BCD7SEG_LZB_EN
    logic [DIGITS-1:0] lzb_next;
    logic [DIGITS-1:0] lzb_sh;

    // Digit i blanks when it and every digit above it are zero; digit 0 never.
    always_comb begin
        logic run;
        lzb_next = '0;
        run      = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run         = run & (BCD[4*i +: 4] == 4'd0);
            lzb_next[i] = run;
        end
    end

    // Mask is taken together with the digits so it always matches the shadow.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            lzb_sh <= '0;
        else if (Load)
            lzb_sh <= lzb_next;
    end

    assign lit_seg = lzb_sh[idx] ? 7'h00 : cur_seg;
`else
    assign lit_seg = cur_seg;
`endif

    assign lit = En && (cnt >= CNT_LIT);

    // Registered pin drive; slot tick marks the first cycle of every slot.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            Segment  <= SEG_BLANK;
            DigitSel <= '0;
            ScanTick <= 1'b0;
        end else begin
            Segment  <= lit ? {dp_sh[idx], lit_seg} : SEG_BLANK;
            DigitSel <= lit ? (DIGITS'(1) << idx) : '0;
            ScanTick <= En && (cnt == '0);
        end
    end

endmodule
